// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes, sequencer states and helpers for the multiply/divide unit.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_OP_NONE  = 3'd0,
    MDU_OP_MULT  = 3'd1,
    MDU_OP_MULTU = 3'd2,
    MDU_OP_DIV   = 3'd3,
    MDU_OP_DIVU  = 3'd4,
    MDU_OP_MTHI  = 3'd5,
    MDU_OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

  localparam int unsigned DIV_ITERS = 32;

  function automatic logic [31:0] abs_if(input logic en, input logic [31:0] v);
    return (en && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider, one iteration per clock.
// Quotient/remainder outputs are the values after the current cycle's step.
module mdu_ctrl_div_iter (
  input  logic        clk,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q;
  logic [33:0] trial;

  always_comb begin
    trial = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};
    if (trial[33]) begin
      rem_d = {rem_q[30:0], quo_q[31]};
      quo_d = {quo_q[30:0], 1'b0};
    end else begin
      rem_d = trial[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quotient  = quo_d;
  assign remainder = rem_d;

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO.
// MDU_DIV0_FAST_EN: divide by zero completes in one cycle with a div_zero pulse.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        stall,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_e;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, dz_q, dz_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic        mul_signed_q, mul_signed_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;
  logic        is_mul, is_div, div_signed, div0_fast, div_load;
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] div_quo, div_rem;

  assign op_e       = mdu_op_e'(op);
  assign is_mul     = (op_e == MDU_OP_MULT) || (op_e == MDU_OP_MULTU);
  assign is_div     = (op_e == MDU_OP_DIV)  || (op_e == MDU_OP_DIVU);
  assign div_signed = (op_e == MDU_OP_DIV);

`ifdef MDU_DIV0_FAST_EN
  assign div0_fast = (src2 == '0);
`else
  assign div0_fast = 1'b0;
`endif

  // Sign-extend only for MULT; low 64 bits of the product are then correct for both.
  assign mul_a   = {{32{mul_signed_q & opa_q[31]}}, opa_q};
  assign mul_b   = {{32{mul_signed_q & opb_q[31]}}, opb_q};
  assign product = mul_a * mul_b;

  mdu_ctrl_div_iter u_div (
    .clk       (clk),
    .load      (div_load),
    .dividend  (abs_if(div_signed, src1)),
    .divisor   (abs_if(div_signed, src2)),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    dz_d         = 1'b0;
    opa_d        = opa_q;
    opb_d        = opb_q;
    mul_signed_d = mul_signed_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    div_load     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && is_mul) begin
          state_d      = ST_MUL;
          cnt_d        = 5'(MUL_LAT - 1);
          opa_d        = src1;
          opb_d        = src2;
          mul_signed_d = (op_e == MDU_OP_MULT);
        end else if (start && is_div && div0_fast) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end else if (start && is_div) begin
          state_d  = ST_DIV;
          cnt_d    = 5'(DIV_ITERS - 1);
          div_load = 1'b1;
          qneg_d   = div_signed && (src1[31] ^ src2[31]);
          rneg_d   = div_signed && src1[31];
        end else if (start && op_e == MDU_OP_MTHI) begin
          hi_d = src1;
        end else if (start && op_e == MDU_OP_MTLO) begin
          lo_d = src1;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          {hi_d, lo_d} = product;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DIV: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          lo_d    = qneg_q ? -div_quo : div_quo;
          hi_d    = rneg_q ? -div_rem : div_rem;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DONE: begin
        if (!stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides any completion or MTHI/MTLO write decided above.
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      done_q       <= 1'b0;
      dz_q         <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      mul_signed_q <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      done_q       <= done_d;
      dz_q         <= dz_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      mul_signed_q <= mul_signed_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
    end
  end

  assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign stall_req = busy || ((state_q == ST_IDLE) && start && (is_mul || is_div));
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: transaction-level reference model checked every cycle,
// directed scenarios with literal results, then randomized traffic.
module tb_mdu_ctrl;

  localparam int unsigned MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, start, stall, flush;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        stall_req, busy, done, div_zero;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .stall     (stall),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

`ifdef MDU_DIV0_FAST_EN
  localparam bit FAST0 = 1'b1;
`else
  localparam bit FAST0 = 1'b0;
`endif

  int unsigned n_vec = 0, n_mis = 0;
  int unsigned cyc = 0;

  // Reference model: an op in flight completes at absolute cycle m_end.
  bit          m_valid = 1'b0;
  bit          m_run = 1'b0, m_hold = 1'b0, m_first = 1'b0, m_dz = 1'b0;
  int unsigned m_end = 0;
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;

  int unsigned n_stall_seen, n_done_seen, n_dz_seen, last_done_cyc;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] rh, output logic [31:0] rl);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    rh = '0;
    rl = '0;
    case (o)
      3'd1: begin
        sp = longint'(sa) * longint'(sb);
        {rh, rl} = sp;
      end
      3'd2: begin
        up = {32'b0, a} * {32'b0, b};
        {rh, rl} = up;
      end
      3'd3: begin
        if (b == 0) begin
          rl = (sa < 0) ? 32'h1 : 32'hFFFF_FFFF;
          rh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000;
          rh = 32'h0;
        end else begin
          rl = sa / sb;
          rh = sa % sb;
        end
      end
      3'd4: begin
        if (b == 0) begin
          rl = 32'hFFFF_FFFF;
          rh = a;
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic clear_obs();
    n_stall_seen  = 0;
    n_done_seen   = 0;
    n_dz_seen     = 0;
    last_done_cyc = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, return #1 after the rising edge.
  task automatic cycle();
    bit exp_stall;
    @(negedge clk);
    if (m_valid) begin
      exp_stall = m_run || (!m_hold && start && op >= 3'd1 && op <= 3'd4);
      chk("stall_req", 32'(stall_req), 32'(exp_stall));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_first));
      chk("div_zero", 32'(div_zero), 32'(m_dz));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (stall_req) n_stall_seen++;
      if (done) begin
        n_done_seen++;
        last_done_cyc = cyc;
      end
      if (div_zero) n_dz_seen++;
    end
    if (rst) begin
      m_valid = 1'b1;
      m_run = 1'b0; m_hold = 1'b0; m_first = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0;
    end else if (m_valid) begin
      if (flush) begin
        m_run = 1'b0; m_hold = 1'b0; m_first = 1'b0; m_dz = 1'b0;
      end else if (m_run) begin
        if (cyc + 1 == m_end) begin
          m_run = 1'b0; m_hold = 1'b1; m_first = 1'b1;
          m_hi = r_hi; m_lo = r_lo;
        end
      end else if (m_hold) begin
        m_first = 1'b0; m_dz = 1'b0;
        if (!stall) m_hold = 1'b0;
      end else begin
        m_first = 1'b0; m_dz = 1'b0;
        if (start) begin
          case (op)
            3'd1, 3'd2: begin
              calc(op, src1, src2, r_hi, r_lo);
              m_run = 1'b1;
              m_end = cyc + MUL_LAT + 1;
            end
            3'd3, 3'd4: begin
              if (FAST0 && src2 == 0) begin
                m_hold = 1'b1; m_first = 1'b1; m_dz = 1'b1;
              end else begin
                calc(op, src1, src2, r_hi, r_lo);
                m_run = 1'b1;
                m_end = cyc + 33;
              end
            end
            3'd5: m_hi = src1;
            3'd6: m_lo = src1;
            default: ;
          endcase
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Run until the DONE cycle, keep stall high there for `hold` cycles, then release.
  task automatic wait_done(input int unsigned hold);
    for (int i = 0; i < 100 && !m_hold; i++) cycle();
    if (!m_hold) begin
      n_vec++;
      n_mis++;
      $display("FAIL wait_done: no completion within 100 cycles (cycle %0d)", cyc);
    end
    stall = 1'b1;
    repeat (hold) cycle();
    stall = 1'b0;
    cycle();
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned hold, output int unsigned t_acc);
    clear_obs();
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    t_acc = cyc;
    cycle();
    wait_done(hold);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int unsigned t0;

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
    op = 3'd0; src1 = '0; src2 = '0;
    repeat (2) cycle();
    rst = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    cycle();

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 0, t0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_stall_cycles", n_stall_seen, 32'd3);
    chk("mult_done_offset", last_done_cyc - t0, 32'd3);

    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 2, t0);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    chk("multu_done_pulses", n_done_seen, 32'd1);
    chk("multu_busy_after", 32'(busy), 32'h0);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 3, t0);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_stall_cycles", n_stall_seen, 32'd33);
    chk("div_done_offset", last_done_cyc - t0, 32'd33);
    chk("div_done_pulses", n_done_seen, 32'd1);

    issue(3'd4, 32'h8000_0000, 32'h0, 0, t0);
`ifdef MDU_DIV0_FAST_EN
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);
    chk("divu0_done_offset", last_done_cyc - t0, 32'd1);
    chk("divu0_dz_pulses", n_dz_seen, 32'd1);
    chk("divu0_stall_cycles", n_stall_seen, 32'd1);
`else
    chk("divu0_hi", hi, 32'h8000_0000);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_done_offset", last_done_cyc - t0, 32'd33);
    chk("divu0_dz_pulses", n_dz_seen, 32'd0);
`endif

    clear_obs();
    start = 1'b1; op = 3'd5; src1 = 32'h1234_5678;
    cycle();
    chk("mthi_hi", hi, 32'h1234_5678);
    op = 3'd6; src1 = 32'h9ABC_DEF0;
    cycle();
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    start = 1'b0; op = 3'd0;
    cycle();
    chk("mt_stall_cycles", n_stall_seen, 32'd0);

    clear_obs();
    start = 1'b1; op = 3'd3; src1 = 32'd100; src2 = 32'd7;
    repeat (10) cycle();
    flush = 1'b1; start = 1'b0; op = 3'd0;
    cycle();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_no_done", n_done_seen, 32'd0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'h9ABC_DEF0);
    start = 1'b1; op = 3'd1; src1 = 32'd5; src2 = 32'd6;
    cycle();
    chk("flush_mult_busy", 32'(busy), 32'h1);
    wait_done(0);
    chk("flush_mult_hi", hi, 32'h0);
    chk("flush_mult_lo", lo, 32'd30);

    start = 1'b1; op = 3'd3; src1 = 32'd1000; src2 = 32'd3;
    repeat (5) cycle();
    rst = 1'b1; start = 1'b0; op = 3'd0;
    cycle();
    rst = 1'b0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 999) == 0);
      flush = ($urandom_range(0, 149) == 0);
      stall = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 9) < 4);
      op    = 3'($urandom_range(0, 7));
      src1  = rnd_opnd();
      src2  = rnd_opnd();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
